// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller. It grants producer/consumer
// requests, drives the RAM strobes and addresses, publishes gray-coded
// pointers, derives occupancy/status flags, and sequences a one-cycle flush.
module gray_fifo_ctrl #(
    parameter int ADDR_LEN      = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_req,
    input  logic                rd_req,
    input  logic                flush,
    output logic                wr_en,
    output logic [ADDR_LEN-1:0] wr_addr,
    output logic                rd_en,
    output logic [ADDR_LEN-1:0] rd_addr,
    output logic [ADDR_LEN:0]   wr_ptr_gray,
    output logic [ADDR_LEN:0]   rd_ptr_gray,
    output logic [ADDR_LEN:0]   count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow,
    output logic                busy
);

    localparam int PW = ADDR_LEN + 1;
    localparam logic [PW-1:0] AFULL_T  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_T = PW'(AEMPTY_THRESH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          flush_enter;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] wr_bin_inc;
    logic [PW-1:0] rd_bin_inc;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign wr_bin_inc = wr_bin + 1'b1;
    assign rd_bin_inc = rd_bin + 1'b1;

    assign wr_addr = wr_bin[ADDR_LEN-1:0];
    assign rd_addr = rd_bin[ADDR_LEN-1:0];

    // Status derived only from registered pointers; full means the write
    // pointer is one lap ahead (top two gray bits inverted, rest equal).
    assign empty        = (wr_ptr_gray == rd_ptr_gray);
    assign full         = (wr_ptr_gray == {~rd_ptr_gray[ADDR_LEN:ADDR_LEN-1],
                                            rd_ptr_gray[ADDR_LEN-2:0]});
    assign count        = wr_bin - rd_bin;
    assign almost_full  = (count >= AFULL_T);
    assign almost_empty = (count <= AEMPTY_T);

    // Next-state and grant logic; grants are suppressed in the flush request
    // cycle and throughout FLUSH.
    always_comb begin
        state_nxt   = state;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        busy        = 1'b0;
        flush_enter = 1'b0;
        case (state)
            ST_RUN: begin
                if (flush) begin
                    state_nxt   = ST_FLUSH;
                    flush_enter = 1'b1;
                end else begin
                    wr_en = wr_req & ~full;
                    rd_en = rd_req & ~empty;
                end
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Write pointer: binary and gray advance together on a granted write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
        end else if (wr_en) begin
            wr_bin      <= wr_bin_inc;
            wr_ptr_gray <= bin2gray(wr_bin_inc);
        end
    end

    // Read pointer: advances on a granted read, or catches up to the write
    // pointer when leaving FLUSH so the FIFO reads back empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_bin      <= '0;
            rd_ptr_gray <= '0;
        end else if (state == ST_FLUSH) begin
            rd_bin      <= wr_bin;
            rd_ptr_gray <= wr_ptr_gray;
        end else if (rd_en) begin
            rd_bin      <= rd_bin_inc;
            rd_ptr_gray <= bin2gray(rd_bin_inc);
        end
    end

    // Sticky error flags; entering FLUSH clears them, but a refused request
    // in that same cycle still sets them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~flush_enter) | (wr_req & ~wr_en);
            underflow <= (underflow & ~flush_enter) | (rd_req & ~rd_en);
        end
    end

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Bench for gray_fifo_ctrl: directed scenarios followed by random traffic,
// all compared against an occupancy-level reference model.
module tb_gray_fifo_ctrl;

    localparam int AL    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en, rd_en;
    logic [AL-1:0] wr_addr, rd_addr;
    logic [AL:0]   wr_ptr_gray, rd_ptr_gray, count;
    logic          full, empty, almost_full, almost_empty;
    logic          overflow, underflow, busy;

    gray_fifo_ctrl #(.ADDR_LEN(AL), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
        .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .rd_req(rd_req),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en),
        .rd_addr(rd_addr), .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: total items ever written/read, flush phase, sticky errors.
    int wtot, rtot;
    bit m_flush, m_ovf, m_unf;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [AL:0] gray_of(input int n);
        logic [AL:0] b;
        b = (AL+1)'(n % (2*DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        int occ;
        occ = wtot - rtot;
        chk("count",        32'(count),        32'(occ));
        chk("full",         32'(full),         32'(occ == DEPTH));
        chk("empty",        32'(empty),        32'(occ == 0));
        chk("almost_full",  32'(almost_full),  32'(occ >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(occ <= AE));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
        chk("busy",         32'(busy),         32'(m_flush));
        chk("wr_ptr_gray",  32'(wr_ptr_gray),  32'(gray_of(wtot)));
        chk("rd_ptr_gray",  32'(rd_ptr_gray),  32'(gray_of(rtot)));
        chk("wr_addr",      32'(wr_addr),      32'(wtot % DEPTH));
        chk("rd_addr",      32'(rd_addr),      32'(rtot % DEPTH));
    endtask

    task automatic model_reset();
        wtot = 0; rtot = 0; m_flush = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_req = 0; rd_req = 0; flush = 0;
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        chk("rst_wr_en", 32'(wr_en), 32'(0));
        chk("rst_rd_en", 32'(rd_en), 32'(0));
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic cycle(input logic w, input logic r, input logic f);
        bit run, ew, er;
        logic [AL:0] pw, pr;
        @(negedge clk);
        wr_req = w; rd_req = r; flush = f;
        #1;
        run = !m_flush;
        ew  = run && !f && w && ((wtot - rtot) < DEPTH);
        er  = run && !f && r && ((wtot - rtot) > 0);
        chk("wr_en", 32'(wr_en), 32'(ew));
        chk("rd_en", 32'(rd_en), 32'(er));
        pw = wr_ptr_gray;
        pr = rd_ptr_gray;
        @(posedge clk);
        if (m_flush) begin
            rtot    = wtot;
            m_flush = 0;
        end else if (f) begin
            m_flush = 1;
            m_ovf   = 0;
            m_unf   = 0;
        end else begin
            wtot += int'(ew);
            rtot += int'(er);
        end
        if (w && !ew) m_ovf = 1;
        if (r && !er) m_unf = 1;
        #1;
        check_all();
        if (ew) chk("wr_gray_onebit", 32'($countones(pw ^ wr_ptr_gray)), 32'(1));
        if (er) chk("rd_gray_onebit", 32'($countones(pr ^ rd_ptr_gray)), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AL:0] gseq [4];
        gseq[0] = 5'b00001; gseq[1] = 5'b00011; gseq[2] = 5'b00010; gseq[3] = 5'b00110;

        // Fill to full, then one refused write.
        do_reset();
        repeat (16) cycle(1, 0, 0);
        chk("tp1_full",  32'(full),        32'(1));
        chk("tp1_count", 32'(count),       32'(16));
        chk("tp1_gray",  32'(wr_ptr_gray), 32'(5'b11000));
        cycle(1, 0, 0);
        chk("tp1_ovf",   32'(overflow),    32'(1));

        // Gray stepping and a full lap of the write pointer.
        do_reset();
        chk("tp2_gray0", 32'(wr_ptr_gray), 32'(5'b00000));
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0);
            chk("tp2_gray_seq", 32'(wr_ptr_gray), 32'(gseq[i]));
        end
        repeat (28) cycle(1, 1, 0);
        chk("tp2_wrap_gray", 32'(wr_ptr_gray), 32'(0));
        chk("tp2_wrap_cnt",  32'(count),       32'(4));

        // Read on empty, then balanced traffic at count 5, then full + both.
        do_reset();
        cycle(0, 1, 0);
        chk("tp3_unf", 32'(underflow), 32'(1));
        repeat (5) cycle(1, 0, 0);
        repeat (10) cycle(1, 1, 0);
        chk("tp3_count",   32'(count),   32'(5));
        chk("tp3_wr_addr", 32'(wr_addr), 32'(15));
        chk("tp3_rd_addr", 32'(rd_addr), 32'(10));
        repeat (11) cycle(1, 0, 0);
        chk("tp4_full", 32'(full), 32'(1));
        cycle(1, 1, 0);
        chk("tp4_count", 32'(count), 32'(15));
        chk("tp4_full0", 32'(full),  32'(0));

        // Flush after 5 writes with a pending underflow; flush during FLUSH ignored.
        do_reset();
        cycle(0, 1, 0);
        repeat (5) cycle(1, 0, 0);
        cycle(0, 0, 1);
        chk("tp5_busy", 32'(busy), 32'(1));
        cycle(0, 0, 1);
        chk("tp5_empty",   32'(empty),       32'(1));
        chk("tp5_count",   32'(count),       32'(0));
        chk("tp5_wgray",   32'(wr_ptr_gray), 32'(5'b00111));
        chk("tp5_rgray",   32'(rd_ptr_gray), 32'(5'b00111));
        chk("tp5_unf_clr", 32'(underflow),   32'(0));
        chk("tp5_ovf_clr", 32'(overflow),    32'(0));
        cycle(0, 0, 0);
        chk("tp5_busy0", 32'(busy), 32'(0));

        // Thresholds, then asynchronous reset while busy.
        do_reset();
        repeat (12) cycle(1, 0, 0);
        chk("tp6_af1", 32'(almost_full), 32'(1));
        cycle(0, 1, 0);
        chk("tp6_af0", 32'(almost_full), 32'(0));
        cycle(0, 0, 1);
        chk("tp6_busy", 32'(busy), 32'(1));
        wr_req = 0; rd_req = 0; flush = 0;
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        chk("tp6_rst_wr_en", 32'(wr_en), 32'(0));
        chk("tp6_rst_rd_en", 32'(rd_en), 32'(0));
        @(negedge clk);
        reset_n = 1;

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_fifo_ctrl.md
Name: gray_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the write/read pointer counters of a 2^ADDR_LEN-entry storage RAM.
- Grants write and read requests and drives RAM enables and addresses.
- Publishes gray-coded pointers for downstream synchronisers and debug taps.
- Produces full/empty/threshold/count status and runs a flush state machine that discards contents without a reset.
- Sits between producer/consumer logic and the FIFO storage array in the test datapath.

Parameters:
ADDR_LEN, 4, RAM address width; depth DEPTH = 2^ADDR_LEN.
AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH (1..DEPTH).
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH (0..DEPTH-1).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
wr_req  in  1  producer write request.
rd_req  in  1  consumer read request.
flush  in  1  single-cycle request to discard all contents.
wr_en  out  1  RAM write strobe (granted write).
wr_addr  out  ADDR_LEN  RAM write address = wr_bin[ADDR_LEN-1:0].
rd_en  out  1  RAM read strobe (granted read).
rd_addr  out  ADDR_LEN  RAM read address = rd_bin[ADDR_LEN-1:0].
wr_ptr_gray  out  ADDR_LEN+1  registered gray code of wr_bin.
rd_ptr_gray  out  ADDR_LEN+1  registered gray code of rd_bin.
count  out  ADDR_LEN+1  occupancy, 0..DEPTH.
full, empty, almost_full, almost_empty  out  1 each  status flags.
overflow, underflow  out  1 each  sticky error flags.
busy  out  1  high while in FLUSH state.

Behaviour:
- Internal state: wr_bin and rd_bin, each ADDR_LEN+1 bits, binary, wrapping modulo 2^(ADDR_LEN+1). The extra MSB is the lap bit.
- Gray outputs are registered: gray = b ^ (b >> 1), updated on the same edge as the binary pointer. Every pointer increment therefore changes exactly one gray bit.
- Reset (reset_n low, asynchronous):
  - wr_bin = rd_bin = 0; both gray outputs = 0.
  - State = RUN; count = 0; empty = 1.
  - full, almost_full, overflow, underflow, busy = 0.
  - almost_empty = 1.
  - wr_en, rd_en = 0.
- Flags and count are combinational from registered pointers only:
  - empty: wr_ptr_gray == rd_ptr_gray.
  - full: wr_ptr_gray == {~rd_ptr_gray[ADDR_LEN:ADDR_LEN-1], rd_ptr_gray[ADDR_LEN-2:0]}.
  - count = wr_bin - rd_bin (modulo, ADDR_LEN+1 bits).
  - Flags reflect a grant the cycle after the grant.
- Grants (combinational, same cycle as request):
  - wr_en = wr_req & ~full & (state==RUN).
  - rd_en = rd_req & ~empty & (state==RUN).
  - A granted op increments its pointer on the next edge. Addresses present the current pointer.
- Simultaneous rd_req & wr_req:
  - Neither full nor empty: both granted, count unchanged.
  - Full: read granted, write blocked (no write-through).
  - Empty: write granted, read blocked (no read-through).
- Sticky errors:
  - overflow sets when wr_req & ~wr_en.
  - underflow sets when rd_req & ~rd_en, including requests made while in FLUSH.
  - Both clear only on reset or on entering FLUSH. If the entering cycle also carries an error request, the set wins.
- State machine, 2 states:
  - RUN: flush=1 -> FLUSH. Grants are suppressed in the flush cycle itself; wr_en = rd_en = 0.
  - FLUSH: held exactly one cycle. busy=1; rd_bin <= wr_bin; rd_ptr_gray <= wr_ptr_gray; -> RUN.
  - flush asserted while in FLUSH is ignored.
  - After return to RUN: empty=1, count=0. The write pointer is not rewound, so gray continuity is preserved.
- Wrap-around: the pointer at 2^(ADDR_LEN+1)-1 increments to 0. Gray wraps from {1,0...0} to 0 with a single-bit change.
- Reset mid-operation (including during FLUSH) returns to the reset state immediately, with no pending grant retained.

Test Plan:
1. Reset release, then 16 writes with ADDR_LEN=4 -> after 16th grant: full=1, count=16, wr_ptr_gray=5'b11000. A 17th wr_req -> wr_en=0, overflow=1.
2. Gray sequence: single writes from reset -> wr_ptr_gray steps 00000, 00001, 00011, 00010, 00110. Check exactly one bit changes per increment across all 32 values including the 31->0 wrap.
3. Empty read, then simultaneous ops:
   - rd_req on empty -> rd_en=0, underflow=1.
   - With count=5, rd_req & wr_req for 10 cycles -> count stays 5; addresses advance 10.
4. Full + simultaneous: at full, assert rd_req & wr_req -> rd_en=1, wr_en=0. Next cycle count=15, full=0.
5. Flush after 5 writes -> flush cycle wr_en=rd_en=0. Next cycle busy=1. Following cycle:
   - empty=1, count=0.
   - rd_ptr_gray = wr_ptr_gray = 5'b00111.
   - overflow/underflow cleared.
6. Thresholds and reset mid-op:
   - 12 writes -> almost_full=1 on count 12, 0 on count 11.
   - Drop reset_n asynchronously while busy=1 -> all outputs at reset values before the next clk edge.
